// File: rtl/mem_pkg.sv
// Shared definitions for the RV64 memory-access stage: funct3 encodings, trap causes,
// FSM state type and access-size decode helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDone,
    StDrain
  } state_e;

  // Low offset bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] byte_en(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-bus request/response channel between the MEM stage (master) and memory (slave).
interface mem_access_stage_if #(
  parameter int unsigned XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            req_wen;
  logic [7:0]      req_wmask;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;

  modport master (
    output req_valid, req_addr, req_wen, req_wmask, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wmask, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/mem_align.sv
// Byte-lane alignment: store data/mask shift-up, or load data shift-down plus extension.
module mem_align
  import mem_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            i_load,
  input  logic [2:0]      i_op,
  input  logic [2:0]      i_off,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_data,
  output logic [7:0]      o_wmask
);

  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_shl;
  logic [XLEN-1:0] w_shr;
  logic [XLEN-1:0] w_ext;

  assign w_shamt = {i_off, 3'b000};
  assign w_shl   = i_data << w_shamt;
  assign w_shr   = i_data >> w_shamt;
  assign o_wmask = byte_en(i_op[1:0]) << i_off;

  always_comb begin
    w_ext = w_shr;
    unique case (i_op)
      F3_B:    w_ext = {{(XLEN-8){w_shr[7]}}, w_shr[7:0]};
      F3_H:    w_ext = {{(XLEN-16){w_shr[15]}}, w_shr[15:0]};
      F3_W:    w_ext = {{(XLEN-32){w_shr[31]}}, w_shr[31:0]};
      F3_BU:   w_ext = {{(XLEN-8){1'b0}}, w_shr[7:0]};
      F3_HU:   w_ext = {{(XLEN-16){1'b0}}, w_shr[15:0]};
      F3_WU:   w_ext = {{(XLEN-32){1'b0}}, w_shr[31:0]};
      default: w_ext = w_shr;
    endcase
  end

  assign o_data = i_load ? w_ext : w_shl;

endmodule

// File: rtl/mem_access_stage.sv
// RV64 MEM stage: turns load/store micro-ops into one valid/ready bus transaction,
// stalling the pipeline until the response arrives, and traps misaligned accesses.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter bit          MISALIGN_EXC = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_mem,
  input  logic            flush,
  input  logic            stall_in,
  input  logic            re_mem,
  input  logic            we_mem_mem,
  input  logic [2:0]      mem_op,
  input  logic [XLEN-1:0] alu_res_mem,
  input  logic [XLEN-1:0] rs2_data_mem,
  output logic [XLEN-1:0] dmem_mem,
  output logic [XLEN-1:0] rw_wdata,
  output logic            stall_mem,
  output logic            except_happen_mem,
  output logic [3:0]      except_cause,
  output logic [XLEN-1:0] except_tval,
  mem_access_stage_if.master bus
);

  state_e          r_state, w_state_d;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  logic [2:0]      r_op, r_off;
  logic            r_wen;
  logic [7:0]      r_wmask;

  logic            w_access, w_misalign, w_exc, w_issue, w_stall, w_req_valid;
  logic [2:0]      w_off, w_off_eff, w_smask;
  logic [XLEN-1:0] w_st_data, w_ld_data;
  logic [7:0]      w_st_wmask, unused_ld_wmask;

  assign w_access   = valid_mem & (re_mem | we_mem_mem) & ~flush;
  assign w_off      = alu_res_mem[2:0];
  assign w_smask    = size_mask(mem_op[1:0]);
  assign w_misalign = |(w_off & w_smask);
  // With trapping disabled a misaligned access is issued at the truncated offset.
  assign w_off_eff  = w_off & ~w_smask;
  assign w_issue    = w_access & ~(MISALIGN_EXC & w_misalign);
  assign w_exc      = MISALIGN_EXC & w_access & w_misalign & ~rst;

  assign except_happen_mem = w_exc;
  assign except_cause      = !w_exc ? 4'd0 : (we_mem_mem ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN);
  assign except_tval       = w_exc ? alu_res_mem : '0;

  mem_align #(.XLEN(XLEN)) u_st_align (
    .i_load  (1'b0),
    .i_op    (mem_op),
    .i_off   (w_off_eff),
    .i_data  (rs2_data_mem),
    .o_data  (w_st_data),
    .o_wmask (w_st_wmask)
  );

  mem_align #(.XLEN(XLEN)) u_ld_align (
    .i_load  (1'b1),
    .i_op    (r_op),
    .i_off   (r_off),
    .i_data  (bus.resp_rdata),
    .o_data  (w_ld_data),
    .o_wmask (unused_ld_wmask)
  );

  always_comb begin
    w_state_d   = r_state;
    w_stall     = 1'b0;
    w_req_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_issue) begin
          w_stall   = 1'b1;
          w_state_d = StReq;
        end
      end
      StReq: begin
        w_req_valid = 1'b1;
        w_stall     = 1'b1;
        // Once accepted the response must still be drained even if flushed.
        if (bus.req_ready) w_state_d = flush ? StDrain : StWait;
        else if (flush)    w_state_d = StIdle;
      end
      StWait: begin
        w_stall = 1'b1;
        if (flush)               w_state_d = bus.resp_valid ? StIdle : StDrain;
        else if (bus.resp_valid) w_state_d = StDone;
      end
      StDrain: begin
        w_stall = w_issue;
        if (bus.resp_valid) w_state_d = StIdle;
      end
      StDone: begin
        if (!stall_in) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_op    <= '0;
      r_off   <= '0;
      r_wen   <= 1'b0;
      r_wmask <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && w_issue) begin
        r_addr  <= {alu_res_mem[XLEN-1:3], 3'b000};
        r_op    <= mem_op;
        r_off   <= w_off_eff;
        r_wen   <= we_mem_mem;
        r_wmask <= w_st_wmask;
        r_wdata <= w_st_data;
      end
      if (r_state == StWait && bus.resp_valid && !flush) begin
        r_rdata <= r_wen ? '0 : w_ld_data;
      end
    end
  end

  assign stall_mem     = w_stall & ~rst;
  assign bus.req_valid = w_req_valid & ~rst;
  assign bus.req_addr  = r_addr;
  assign bus.req_wen   = r_wen;
  assign bus.req_wmask = r_wmask;
  assign bus.req_wdata = r_wdata;
  assign rw_wdata      = r_wdata;
  assign dmem_mem      = (r_state == StDone) ? r_rdata : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: inputs driven 1ns after posedge, outputs checked at negedge.
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_mem, flush, stall_in, re_mem, we_mem_mem;
  logic [2:0]  mem_op;
  logic [63:0] alu_res_mem, rs2_data_mem;
  logic [63:0] dmem_mem, rw_wdata, except_tval;
  logic        stall_mem, except_happen_mem;
  logic [3:0]  except_cause;

  int n_chk  = 0;
  int n_pass = 0;
  int hs_cnt = 0;

  mem_access_stage_if #(.XLEN(64)) bus ();

  mem_access_stage #(.XLEN(64), .MISALIGN_EXC(1'b1)) dut (
    .clk               (clk),
    .rst               (rst),
    .valid_mem         (valid_mem),
    .flush             (flush),
    .stall_in          (stall_in),
    .re_mem            (re_mem),
    .we_mem_mem        (we_mem_mem),
    .mem_op            (mem_op),
    .alu_res_mem       (alu_res_mem),
    .rs2_data_mem      (rs2_data_mem),
    .dmem_mem          (dmem_mem),
    .rw_wdata          (rw_wdata),
    .stall_mem         (stall_mem),
    .except_happen_mem (except_happen_mem),
    .except_cause      (except_cause),
    .except_tval       (except_tval),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.req_valid && bus.req_ready) hs_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_mem = 0; flush = 0; stall_in = 0; re_mem = 0; we_mem_mem = 0;
    mem_op = 0; alu_res_mem = 0; rs2_data_mem = 0;
    bus.req_ready = 0; bus.resp_valid = 0; bus.resp_rdata = 0;
  endtask

  task automatic drive(input logic st, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] d);
    valid_mem = 1; re_mem = ~st; we_mem_mem = st; mem_op = op;
    alu_res_mem = a; rs2_data_mem = d;
  endtask

  // One aligned access with an always-ready bus answering lat cycles after acceptance.
  task automatic xact(input string tag, input logic st, input logic [2:0] op,
                      input logic [63:0] a, input logic [63:0] d, input int lat,
                      input logic [63:0] rdata, input logic [63:0] exp_dmem,
                      input logic [7:0] exp_wmask, input logic [63:0] exp_wdata,
                      input int exp_stalls);
    int stalls = 0;
    int nreq   = 0;
    int since  = 0;
    bit acc    = 0;
    bit done   = 0;
    drive(st, op, a, d);
    bus.req_ready  = 1;
    bus.resp_rdata = rdata;
    for (int c = 0; c < 40 && !done; c++) begin
      bus.resp_valid = acc && (since == lat);
      look();
      if (bus.req_valid) begin
        nreq++;
        check({tag, " req_addr"}, bus.req_addr, {a[63:3], 3'b000});
        check({tag, " req_wen"}, {63'b0, bus.req_wen}, {63'b0, st});
        if (st) begin
          check({tag, " wmask"}, {56'b0, bus.req_wmask}, {56'b0, exp_wmask});
          check({tag, " req_wdata"}, bus.req_wdata, exp_wdata);
          check({tag, " rw_wdata"}, rw_wdata, exp_wdata);
        end
      end
      if (stall_mem) stalls++;
      else begin
        done = 1;
        check({tag, " dmem"}, dmem_mem, exp_dmem);
      end
      if (acc) since++;
      if (bus.req_valid && bus.req_ready) begin
        acc   = 1;
        since = 1;
      end
      adv();
    end
    check({tag, " completed"}, {63'b0, done}, 64'd1);
    check({tag, " stall cycles"}, 64'(stalls), 64'(exp_stalls));
    check({tag, " requests"}, 64'(nreq), 64'd1);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs0;
    idle_inputs();
    rst = 1;
    adv(); adv();
    look();
    check("reset req_valid", {63'b0, bus.req_valid}, 64'd0);
    check("reset stall", {63'b0, stall_mem}, 64'd0);
    check("reset dmem", dmem_mem, 64'd0);
    check("reset exc", {63'b0, except_happen_mem}, 64'd0);
    adv();
    rst = 0;
    adv();

    xact("LW", 0, F3_W, 64'h1004, 64'h0, 2, 64'h8000_0001_1234_5678,
         64'hFFFF_FFFF_8000_0001, 8'h00, 64'h0, 4);
    xact("SB", 1, F3_B, 64'h2003, 64'hAB, 1, 64'h0, 64'h0, 8'h08, 64'h0000_0000_AB00_0000, 3);
    xact("SH", 1, F3_H, 64'h2006, 64'h1234_ABCD, 1, 64'h0, 64'h0, 8'hC0,
         64'hABCD_0000_0000_0000, 3);
    xact("LB", 0, F3_B, 64'h1007, 64'h80FF_0000_0000_0000, 1, 64'h80FF_0000_0000_0000,
         64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0, 3);
    xact("LHU", 0, F3_HU, 64'h1006, 64'h0, 1, 64'h8001_0000_0000_0000, 64'h8001, 8'h00, 64'h0, 3);
    xact("LWU", 0, F3_WU, 64'h1004, 64'h0, 1, 64'h8000_0001_1234_5678, 64'h8000_0001,
         8'h00, 64'h0, 3);

    // Misaligned load and store trap without touching the bus.
    drive(0, F3_H, 64'h3001, 64'h0);
    bus.req_ready = 1;
    look();
    check("LH mis exc", {63'b0, except_happen_mem}, 64'd1);
    check("LH mis cause", {60'b0, except_cause}, 64'd4);
    check("LH mis tval", except_tval, 64'h3001);
    check("LH mis stall", {63'b0, stall_mem}, 64'd0);
    check("LH mis req_valid", {63'b0, bus.req_valid}, 64'd0);
    adv();
    look();
    check("LH mis req_valid next", {63'b0, bus.req_valid}, 64'd0);
    adv();
    drive(1, F3_W, 64'h2002, 64'h55);
    look();
    check("SW mis exc", {63'b0, except_happen_mem}, 64'd1);
    check("SW mis cause", {60'b0, except_cause}, 64'd6);
    adv();
    idle_inputs();
    look();
    check("exc cleared", {63'b0, except_happen_mem}, 64'd0);
    adv();

    // SD withdrawn by a flush while the bus is not ready.
    hs0 = hs_cnt;
    drive(1, F3_D, 64'h5000, 64'hDEAD_BEEF_0000_1111);
    look(); check("SD idle stall", {63'b0, stall_mem}, 64'd1); adv();
    look(); check("SD req c1", {63'b0, bus.req_valid}, 64'd1); adv();
    look(); check("SD req c2", {63'b0, bus.req_valid}, 64'd1); adv();
    flush = 1;
    look(); adv();
    flush = 0; valid_mem = 0;
    look();
    check("SD withdrawn req_valid", {63'b0, bus.req_valid}, 64'd0);
    check("SD withdrawn stall", {63'b0, stall_mem}, 64'd0);
    adv(); look(); adv();
    bus.req_ready = 1;
    look();
    check("SD no reissue", {63'b0, bus.req_valid}, 64'd0);
    check("SD no handshake", 64'(hs_cnt - hs0), 64'd0);
    adv();
    idle_inputs();

    // LBU flushed in WAIT; stale response drained before the next LD issues.
    drive(0, F3_BU, 64'h4007, 64'h0);
    bus.req_ready = 1;
    look(); adv();
    look(); check("LBU req_addr", bus.req_addr, 64'h4000); adv();
    bus.req_ready = 0;
    flush = 1;
    look(); check("LBU wait stall", {63'b0, stall_mem}, 64'd1); adv();
    flush = 0;
    drive(0, F3_D, 64'h6008, 64'h0);
    bus.req_ready = 1;
    look();
    check("drain holds new access", {63'b0, stall_mem}, 64'd1);
    check("drain no req c1", {63'b0, bus.req_valid}, 64'd0);
    adv();
    bus.resp_valid = 1;
    bus.resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    look();
    check("drain no req c2", {63'b0, bus.req_valid}, 64'd0);
    check("drain dmem", dmem_mem, 64'd0);
    adv();
    bus.resp_valid = 0;
    xact("LD after drain", 0, F3_D, 64'h6008, 64'h0, 1, 64'h0123_4567_89AB_CDEF,
         64'h0123_4567_89AB_CDEF, 8'h00, 64'h0, 3);

    // LD completes under a downstream stall.
    hs0 = hs_cnt;
    drive(0, F3_D, 64'h7000, 64'h0);
    bus.req_ready  = 1;
    bus.resp_rdata = 64'h1122_3344_5566_7788;
    stall_in = 1;
    adv(); adv();
    bus.req_ready  = 0;
    bus.resp_valid = 1;
    adv();
    bus.resp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      look();
      check("LD held dmem", dmem_mem, 64'h1122_3344_5566_7788);
      check("LD held stall", {63'b0, stall_mem}, 64'd0);
      check("LD held no req", {63'b0, bus.req_valid}, 64'd0);
      adv();
    end
    stall_in = 0;
    look(); check("LD release dmem", dmem_mem, 64'h1122_3344_5566_7788); adv();
    idle_inputs();
    look();
    check("LD retired dmem", dmem_mem, 64'd0);
    check("LD single transaction", 64'(hs_cnt - hs0), 64'd1);
    adv();

    // Reset during WAIT; the late response must be ignored.
    drive(0, F3_W, 64'h8000, 64'h0);
    bus.req_ready = 1;
    adv(); adv();
    bus.req_ready = 0;
    rst = 1;
    valid_mem = 0;
    adv();
    look();
    check("rst req_valid", {63'b0, bus.req_valid}, 64'd0);
    check("rst stall", {63'b0, stall_mem}, 64'd0);
    check("rst dmem", dmem_mem, 64'd0);
    check("rst exc", {63'b0, except_happen_mem}, 64'd0);
    check("rst req_addr", bus.req_addr, 64'd0);
    adv();
    rst = 0;
    bus.resp_valid = 1;
    bus.resp_rdata = 64'hFFFF;
    adv();
    bus.resp_valid = 0;
    look();
    check("post-rst resp ignored dmem", dmem_mem, 64'd0);
    check("post-rst stall", {63'b0, stall_mem}, 64'd0);
    adv();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
